muldiv_iter: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in XLEN, that extends the single-cycle ALU op set with the M-extension operations. Sits beside the ALU in the execute stage. Takes one operation through a valid/ready handshake, computes it over multiple cycles with a radix-2 shift-add / restoring-divide datapath, and holds the result until the consumer accepts it. Carries a destination tag so the pipeline can route the writeback.

---
 rtl/muldiv_iter.sv | 234 +++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide. Optional macro MULDIV_FAST_MUL_EN: one-cycle multiply.
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0]   ONE   = XLEN'(1);
    localparam logic [2*XLEN-1:0] PONE  = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   ONES  = '1;
    localparam logic [XLEN-1:0]   MINV  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]     LAST  = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_result;
    logic [TAG_W-1:0]  r_out_tag;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_sa;
    logic [XLEN:0]     r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opb;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN:0]     w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;

    // Operand signedness and magnitudes for the op being offered
    always_comb begin
        w_a_signed = (in_op == 3'd1) || (in_op == 3'd2) ||
                     (in_op == 3'd4) || (in_op == 3'd6);
        w_b_signed = (in_op == 3'd1) || (in_op == 3'd4) ||
                     (in_op == 3'd6);
        w_sa    = w_a_signed && in_a[XLEN-1];
        w_sb    = w_b_signed && in_b[XLEN-1];
        w_mag_a = w_sa ? (~in_a + ONE) : in_a;
        w_mag_b = w_sb ? (~in_b + ONE) : in_b;
    end

    // Divide special cases resolved at accept without iterating
    always_comb begin
        w_div_zero    = in_op[2] && (in_b == '0);
        w_ovf         = (in_op == 3'd4 || in_op == 3'd6) &&
                        (in_a == MINV) && (in_b == ONES);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = in_op[1] ? in_a : ONES;
        end else if (w_ovf) begin
            w_special_res = in_op[1] ? '0 : in_a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    logic [2*XLEN-1:0] w_fast_sgn;
    logic [XLEN-1:0]   w_fast_res;

    // Single-cycle product of magnitudes with sign restored
    always_comb begin
        w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
        w_fast_sgn  = (w_sa ^ w_sb) ? (~w_fast_prod + PONE) : w_fast_prod;
        w_fast_res  = (in_op == 3'd0) ? w_fast_sgn[XLEN-1:0]
                                      : w_fast_sgn[2*XLEN-1:XLEN];
    end
`endif

    // One radix-2 step: shift-add for multiply, restoring step for divide
    always_comb begin
        w_mul_sum = r_lo[0] ? (r_hi + {1'b0, r_opb}) : r_hi;
        w_shift   = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_opb};
        if (!r_op[2]) begin
            w_hi_n = {1'b0, w_mul_sum[XLEN:1]};
            w_lo_n = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            w_hi_n = w_diff;
            w_lo_n = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_hi_n = w_shift;
            w_lo_n = {r_lo[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and word selection after the last iteration
    always_comb begin
        w_prod   = {r_hi[XLEN-1:0], r_lo};
        w_prod_s = r_neg ? (~w_prod + PONE) : w_prod;
        w_quo_s  = r_neg ? (~r_lo + ONE) : r_lo;
        w_rem_s  = r_sa ? (~r_hi[XLEN-1:0] + ONE) : r_hi[XLEN-1:0];
        case (r_op)
            3'd0:          w_fix_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_fix_res = w_quo_s;
            default:       w_fix_res = w_rem_s;
        endcase
    end

    // Control FSM with registered handshake outputs and datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_cnt        <= '0;
            r_op         <= '0;
            r_neg        <= 1'b0;
            r_sa         <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_opb        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= in_op;
                        r_out_tag  <= in_tag;
                        r_neg      <= w_sa ^ w_sb;
                        r_sa       <= w_sa;
                        r_hi       <= '0;
                        r_lo       <= w_mag_a;
                        r_opb      <= w_mag_b;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (w_div_zero || w_ovf) begin
                            r_out_result <= w_special_res;
                            r_out_valid  <= 1'b1;
                            r_state      <= ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!in_op[2]) begin
                            r_out_result <= w_fast_res;
                            r_out_valid  <= 1'b1;
                            r_state      <= ST_DONE;
`endif
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_hi <= w_hi_n;
                        r_lo <= w_lo_n;
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_out_result <= w_fix_res;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vectors, random ops
// against an arithmetic reference, backpressure, flush and reset.
module tb_muldiv_iter;

    localparam int XLEN = 32;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        flush = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    muldiv_iter #(.XLEN(XLEN), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Drives one request, counts edges to out_valid (accept edge = 1),
    // then consumes the result after 'hold' stalled cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input int hold, output logic [31:0] res,
                         output logic [4:0] otag, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 3'($urandom);
        in_a = $urandom;
        in_b = $urandom;
        in_tag = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_result;
        otag = out_tag;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_result !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_result got=%h exp=0", out_result);
        end
        checks++;
        if (out_tag !== 5'h0) begin
            failures++;
            $display("FAIL reset_out_tag got=%h exp=0", out_tag);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  ops[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5,
                                 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as[14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] bs[14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd0, 32'd0};
        logic [31:0] es[14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        int          ls[14] = '{34, 34, 34, 34, 34, 34, 34, 34,
                                1, 1, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  otag;
        int          lat;
        int          el;
        for (int i = 0; i < 14; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 3), 0, res, otag, lat);
            el = ls[i];
`ifdef MULDIV_FAST_MUL_EN
            if (!ops[i][2]) el = 1;
`endif
            checks++;
            if (res !== es[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] got=%h exp=%h",
                         i, res, es[i]);
            end
            checks++;
            if (otag !== 5'(i + 3)) begin
                failures++;
                $display("FAIL directed_tag[%0d] got=%0d exp=%0d",
                         i, otag, i + 3);
            end
            checks++;
            if (lat != el) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d",
                         i, lat, el);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  tag, otag;
        int          lat, sel;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = $urandom_range(1, 20);
            if (sel == 3) a = -a;
            tag = 5'($urandom);
            issue(op, a, b, tag, $urandom_range(0, 3), res, otag, lat);
            checks++;
            if (res !== ref_model(op, a, b)) begin
                failures++;
                $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h",
                         op, a, b, res, ref_model(op, a, b));
            end
            checks++;
            if (otag !== tag) begin
                failures++;
                $display("FAIL random_tag got=%0d exp=%0d", otag, tag);
            end
            checks++;
            if (lat != exp_lat(op, a, b)) begin
                failures++;
                $display("FAIL random_latency op=%0d got=%0d exp=%0d",
                         op, lat, exp_lat(op, a, b));
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL random_release got=%b%b exp=10",
                         in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd5;
        in_a = 32'd1000;
        in_b = 32'd3;
        in_tag = 5'd21;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid got=%b exp=1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_op = 3'd0;
            in_a = $urandom;
            in_b = $urandom;
            in_tag = 5'd2;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_result !== 32'd333 || out_tag !== 5'd21) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%b%b %h %0d exp=10 14d 21",
                         i, out_valid, in_ready, out_result, out_tag);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got=%b%b%b exp=100",
                     in_ready, out_valid, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored got=%b%b exp=00", out_valid, busy);
        end
    endtask

    task automatic test_flush;
        int          seen;
        int          lat;
        logic [31:0] res;
        logic [4:0]  otag;
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd5;
        in_a = 32'd100;
        in_b = 32'd7;
        in_tag = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc got=%b%b%b exp=010",
                     busy, in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_no_result got=%0d exp=0", seen);
        end
        issue(3'd0, 32'd3, 32'd4, 5'd9, 0, res, otag, lat);
        checks++;
        if (res !== 32'd12 || otag !== 5'd9) begin
            failures++;
            $display("FAIL flush_next got=%h/%0d exp=c/9", res, otag);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd4;
        in_a = 32'd9;
        in_b = 32'd0;
        in_tag = 5'd1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done got=%b%b exp=01", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_op = 3'd4;
        in_b = 32'd0;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_accept got=%b%b exp=00",
                     busy, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd1;
        in_a = 32'h1234_5678;
        in_b = 32'h9ABC_DEF0;
        in_tag = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_result !== 32'h0 || out_tag !== 5'h0) begin
            failures++;
            $display("FAIL reset_mid got=%b%b%b %h %0d exp=010 0 0",
                     busy, in_ready, out_valid, out_result, out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
